// File: rtl/tmds_rx_decoder.sv
// TMDS receive decoder: serial bit in, word alignment by control-token hunting, 8b/10b data and control decode.
// Optional lock-loss counter output o_lock_loss_cnt is built when TMDS_RX_ERR_CNT_EN is defined.
module tmds_rx_decoder #(
  parameter int LOCK_TOKENS = 4,
  parameter int MAX_GAP     = 1023
) (
  input  logic        sys_clk,
  input  logic        sys_reset_n,
  input  logic        tmds_bit,
  output logic [7:0]  o_data,
  output logic [1:0]  o_ctrl,
  output logic        o_de,
  output logic        o_valid,
  output logic        o_locked
`ifdef TMDS_RX_ERR_CNT_EN
  ,
  output logic [15:0] o_lock_loss_cnt
`endif
);

  localparam int TOK_W = $clog2(LOCK_TOKENS + 1);
  localparam int GAP_W = $clog2(MAX_GAP + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         sreg_q, sreg_d;
  logic [3:0]         phase_q, phase_d;
  logic [TOK_W-1:0]   tok_cnt_q, tok_cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gap_inc;
  logic [TOK_W-1:0]   tok_inc;
  logic [7:0]         data_q, data_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               de_q, de_d;
  logic               valid_q, valid_d;
  logic               locked_q, locked_d;

  logic               is_token;
  logic [1:0]         token_val;
  logic [7:0]         d_raw;
  logic [7:0]         dec_data;
  logic               boundary;

  always_comb begin
    is_token  = 1'b1;
    token_val = 2'b00;
    case (sreg_q)
      10'b1101010100: token_val = 2'b00;
      10'b0010101011: token_val = 2'b01;
      10'b0101010100: token_val = 2'b10;
      10'b1010101011: token_val = 2'b11;
      default:        is_token  = 1'b0;
    endcase
  end

  // q[9] undoes the optional inversion, q[8] selects XOR vs XNOR chaining
  always_comb begin
    d_raw       = sreg_q[9] ? ~sreg_q[7:0] : sreg_q[7:0];
    dec_data    = 8'h00;
    dec_data[0] = d_raw[0];
    for (int i = 1; i < 8; i++) begin
      dec_data[i] = sreg_q[8] ? (d_raw[i] ^ d_raw[i-1]) : ~(d_raw[i] ^ d_raw[i-1]);
    end
  end

  assign boundary = (phase_q == 4'd9);
  assign gap_inc  = gap_q + GAP_W'(1);
  assign tok_inc  = tok_cnt_q + TOK_W'(1);

  always_comb begin
    state_d   = state_q;
    sreg_d    = {tmds_bit, sreg_q[9:1]};
    phase_d   = boundary ? 4'd0 : phase_q + 4'd1;
    tok_cnt_d = tok_cnt_q;
    gap_d     = gap_q;
    data_d    = data_q;
    ctrl_d    = ctrl_q;
    de_d      = de_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;

    case (state_q)
      SEARCH: begin
        if (is_token) begin
          phase_d   = 4'd0;
          tok_cnt_d = TOK_W'(1);
          state_d   = VERIFY;
        end
      end

      VERIFY: begin
        if (boundary) begin
          if (is_token) begin
            tok_cnt_d = tok_inc;
            if (tok_inc == TOK_W'(LOCK_TOKENS)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              gap_d    = '0;
            end
          end else begin
            state_d   = SEARCH;
            tok_cnt_d = '0;
          end
        end
      end

      LOCKED: begin
        if (boundary) begin
          if (is_token) begin
            gap_d   = '0;
            valid_d = 1'b1;
            de_d    = 1'b0;
            ctrl_d  = token_val;
            data_d  = 8'h00;
          end else if (gap_inc == GAP_W'(MAX_GAP)) begin
            // too long without a token: assume alignment lost, drop this symbol
            gap_d     = gap_inc;
            state_d   = SEARCH;
            locked_d  = 1'b0;
            tok_cnt_d = '0;
          end else begin
            gap_d   = gap_inc;
            valid_d = 1'b1;
            de_d    = 1'b1;
            data_d  = dec_data;
          end
        end
      end

      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q   <= SEARCH;
      sreg_q    <= '0;
      phase_q   <= '0;
      tok_cnt_q <= '0;
      gap_q     <= '0;
      data_q    <= '0;
      ctrl_q    <= '0;
      de_q      <= 1'b0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      phase_q   <= phase_d;
      tok_cnt_q <= tok_cnt_d;
      gap_q     <= gap_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      de_q      <= de_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
    end
  end

  assign o_data   = data_q;
  assign o_ctrl   = ctrl_q;
  assign o_de     = de_q;
  assign o_valid  = valid_q;
  assign o_locked = locked_q;

`ifdef TMDS_RX_ERR_CNT_EN
  logic [15:0] loss_cnt_q, loss_cnt_d;
  logic        lost_lock;

  // only a LOCKED -> SEARCH drop counts; failed verification does not
  always_comb begin
    lost_lock  = (state_q == LOCKED) && (state_d == SEARCH);
    loss_cnt_d = loss_cnt_q;
    if (lost_lock && (loss_cnt_q != 16'hFFFF)) begin
      loss_cnt_d = loss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign o_lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Self-checking bench for tmds_rx_decoder: directed lock/decode/timeout/reset scenarios plus random symbol streams,
// compared every cycle against a cycle-indexed behavioural model of the alignment and decode rules.
`timescale 1ns/1ps
module tb_tmds_rx_decoder;

  localparam int LOCK_TOKENS = 4;
  localparam int MAX_GAP     = 8;

  localparam logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011,
                                     10'b0101010100, 10'b1010101011};
  localparam logic [9:0] D_ZERO = 10'b0100000000;
  localparam logic [9:0] D_FE   = 10'b1011111111;

  localparam int M_SEARCH = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCKED = 2;

  logic        sys_clk     = 1'b0;
  logic        sys_reset_n = 1'b0;
  logic        tmds_bit    = 1'b0;
  logic [7:0]  o_data;
  logic [1:0]  o_ctrl;
  logic        o_de;
  logic        o_valid;
  logic        o_locked;
`ifdef TMDS_RX_ERR_CNT_EN
  logic [15:0] o_lock_loss_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  tmds_rx_decoder #(
    .LOCK_TOKENS(LOCK_TOKENS),
    .MAX_GAP    (MAX_GAP)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_reset_n(sys_reset_n),
    .tmds_bit   (tmds_bit),
    .o_data     (o_data),
    .o_ctrl     (o_ctrl),
    .o_de       (o_de),
    .o_valid    (o_valid),
    .o_locked   (o_locked)
`ifdef TMDS_RX_ERR_CNT_EN
    ,
    .o_lock_loss_cnt(o_lock_loss_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // model state: last ten received bits (oldest first) and the absolute cycle of the next symbol boundary
  bit         win [$];
  int         m_cyc     = 0;
  int         m_next_b  = -1;
  int         m_mode    = M_SEARCH;
  int         m_tokens  = 0;
  int         m_gap     = 0;
  int         m_loss    = 0;
  logic       m_locked  = 1'b0;
  logic       m_valid   = 1'b0;
  logic       m_de      = 1'b0;
  logic [1:0] m_ctrl    = 2'b00;
  logic [7:0] m_data    = 8'h00;

  function automatic logic [7:0] decodeData(input logic [9:0] q);
    logic [7:0] d;
    d = q[9] ? ~q[7:0] : q[7:0];
    return d ^ (d << 1) ^ (q[8] ? 8'h00 : 8'hFE);
  endfunction

  function automatic logic [12:0] mk(input logic l, input logic v, input logic de,
                                     input logic [1:0] c, input logic [7:0] d);
    return {l, v, de, c, d};
  endfunction

  function void modelReset();
    win.delete();
    for (int j = 0; j < 10; j++) win.push_back(1'b0);
    m_cyc    = 0;
    m_next_b = -1;
    m_mode   = M_SEARCH;
    m_tokens = 0;
    m_gap    = 0;
    m_loss   = 0;
    m_locked = 1'b0;
    m_valid  = 1'b0;
    m_de     = 1'b0;
    m_ctrl   = 2'b00;
    m_data   = 8'h00;
  endfunction

  function void modelStep();
    logic [9:0] w;
    logic       is_tok;
    logic [1:0] tv;
    logic       bnd;
    for (int j = 0; j < 10; j++) w[j] = win[j];
    is_tok = 1'b0;
    tv     = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (w == TOK[k]) begin
        is_tok = 1'b1;
        tv     = 2'(k);
      end
    end
    m_cyc   = m_cyc + 1;
    bnd     = (m_cyc == m_next_b);
    if (bnd) m_next_b = m_cyc + 10;
    m_valid = 1'b0;
    case (m_mode)
      M_SEARCH: begin
        if (is_tok) begin
          m_mode   = M_VERIFY;
          m_tokens = 1;
          m_next_b = m_cyc + 10;
        end
      end
      M_VERIFY: begin
        if (bnd) begin
          if (is_tok) begin
            m_tokens = m_tokens + 1;
            if (m_tokens == LOCK_TOKENS) begin
              m_mode   = M_LOCKED;
              m_locked = 1'b1;
              m_gap    = 0;
            end
          end else begin
            m_mode   = M_SEARCH;
            m_tokens = 0;
          end
        end
      end
      default: begin
        if (bnd) begin
          if (is_tok) begin
            m_gap   = 0;
            m_valid = 1'b1;
            m_de    = 1'b0;
            m_ctrl  = tv;
            m_data  = 8'h00;
          end else begin
            m_gap = m_gap + 1;
            if (m_gap == MAX_GAP) begin
              m_mode   = M_SEARCH;
              m_locked = 1'b0;
              m_tokens = 0;
              if (m_loss < 65535) m_loss = m_loss + 1;
            end else begin
              m_valid = 1'b1;
              m_de    = 1'b1;
              m_data  = decodeData(w);
            end
          end
        end
      end
    endcase
    win.push_back(tmds_bit);
    void'(win.pop_front());
  endfunction

  initial modelReset();

  always @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) modelReset();
    else              modelStep();
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [12:0] outVec();
    return {o_locked, o_valid, o_de, o_ctrl, o_data};
  endfunction

  // per-cycle comparison against the model, sampled away from the rising edge
  always @(negedge sys_clk) begin
    checkOutput("cycle", {3'b000, outVec()}, {3'b000, mk(m_locked, m_valid, m_de, m_ctrl, m_data)});
`ifdef TMDS_RX_ERR_CNT_EN
    checkOutput("cycle_loss_cnt", o_lock_loss_cnt, 16'(m_loss));
`endif
  end

  // hand-computed expectation checked while the following symbol is being sent
  logic        lit_pend  = 1'b0;
  logic        lit_chk0  = 1'b0;
  logic        lit_lock0 = 1'b0;
  logic [12:0] lit_vec   = '0;
  string       lit_name  = "";

  task automatic expectNext(input string name, input logic chk0, input logic lock0, input logic [12:0] vec);
    lit_pend  = 1'b1;
    lit_chk0  = chk0;
    lit_lock0 = lock0;
    lit_vec   = vec;
    lit_name  = name;
  endtask

  task automatic sendBit(input logic b);
    @(posedge sys_clk);
    #1 tmds_bit = b;
  endtask

  task automatic sendPartial(input logic [9:0] q, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sendBit(q[i]);
      if (i == 0 && lit_pend && lit_chk0)
        checkOutput({lit_name, "_pre"}, {15'd0, o_locked}, {15'd0, lit_lock0});
      if (i == 1 && lit_pend) begin
        checkOutput(lit_name, {3'b000, outVec()}, {3'b000, lit_vec});
        lit_pend = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic [9:0] q);
    sendPartial(q, 10);
  endtask

  initial begin
    int r;
    int n;
    sys_reset_n = 1'b0;
    tmds_bit    = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 sys_reset_n = 1'b1;
    checkOutput("reset_state", {3'b000, outVec()}, 16'h0000);

    // lock at a 3-bit offset, then token, data and all control values
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    repeat (4) applyStimulus(TOK[0]);
    expectNext("lock_rise", 1'b1, 1'b0, mk(1, 0, 0, 2'd0, 8'h00));
    applyStimulus(TOK[0]);
    expectNext("tok00_out", 1'b0, 1'b0, mk(1, 1, 0, 2'd0, 8'h00));
    applyStimulus(D_ZERO);
    expectNext("data_00", 1'b0, 1'b0, mk(1, 1, 1, 2'd0, 8'h00));
    applyStimulus(D_FE);
    expectNext("data_fe", 1'b0, 1'b0, mk(1, 1, 1, 2'd0, 8'hFE));
    applyStimulus(TOK[1]);
    expectNext("ctrl_01", 1'b0, 1'b0, mk(1, 1, 0, 2'd1, 8'h00));
    applyStimulus(TOK[2]);
    expectNext("ctrl_10", 1'b0, 1'b0, mk(1, 1, 0, 2'd2, 8'h00));
    applyStimulus(TOK[3]);
    expectNext("ctrl_11", 1'b0, 1'b0, mk(1, 1, 0, 2'd3, 8'h00));
    applyStimulus(TOK[0]);
    expectNext("ctrl_00", 1'b0, 1'b0, mk(1, 1, 0, 2'd0, 8'h00));

    // gap timeout: eight data symbols in a row
    repeat (MAX_GAP) applyStimulus(D_ZERO);
    expectNext("gap_drop", 1'b1, 1'b1, mk(0, 0, 1, 2'd0, 8'h00));

    // verify failure: two tokens, a data symbol, then four tokens to relock
    applyStimulus(TOK[0]);
`ifdef TMDS_RX_ERR_CNT_EN
    checkOutput("loss_after_gap", o_lock_loss_cnt, 16'd1);
`endif
    applyStimulus(TOK[0]);
    applyStimulus(D_ZERO);
    expectNext("verify_fail", 1'b0, 1'b0, mk(0, 0, 1, 2'd0, 8'h00));
    repeat (4) applyStimulus(TOK[0]);
    expectNext("relock", 1'b1, 1'b0, mk(1, 0, 1, 2'd0, 8'h00));
    applyStimulus(TOK[0]);
`ifdef TMDS_RX_ERR_CNT_EN
    checkOutput("loss_verify_no_count", o_lock_loss_cnt, 16'd1);
`endif

    // random token bursts, random codes and bit slips
    for (int s = 0; s < 300; s++) begin
      r = $urandom_range(0, 99);
      if (r < 45) begin
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) applyStimulus(TOK[$urandom_range(0, 3)]);
      end else if (r < 90) begin
        n = $urandom_range(1, 10);
        for (int k = 0; k < n; k++) applyStimulus(10'($urandom));
      end else begin
        n = $urandom_range(1, 9);
        for (int k = 0; k < n; k++) sendBit(1'($urandom));
      end
    end

    // reset in the middle of a symbol while locked
    repeat (20) applyStimulus(TOK[0]);
    expectNext("prereset_locked", 1'b0, 1'b0, mk(1, 1, 0, 2'd0, 8'h00));
    sendPartial(TOK[1], 5);
    #2 sys_reset_n = 1'b0;
    #1 checkOutput("reset_async", {3'b000, outVec()}, 16'h0000);
`ifdef TMDS_RX_ERR_CNT_EN
    checkOutput("reset_loss_cnt", o_lock_loss_cnt, 16'd0);
`endif
    repeat (2) @(posedge sys_clk);
    #1 sys_reset_n = 1'b1;
    repeat (3) applyStimulus(TOK[0]);
    expectNext("reset_no_early_lock", 1'b0, 1'b0, mk(0, 0, 0, 2'd0, 8'h00));
    applyStimulus(TOK[0]);
    expectNext("reset_relock", 1'b1, 1'b0, mk(1, 0, 0, 2'd0, 8'h00));
    applyStimulus(TOK[3]);
    expectNext("post_reset_tok", 1'b0, 1'b0, mk(1, 1, 0, 2'd3, 8'h00));
    applyStimulus(TOK[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
